// File: rtl/hex_entry_ctrl_if.sv
// Handshake and counter-chain signal bundle for hex_entry_ctrl.
// The slave modport is the controller's view; master is the environment's view.
`timescale 1ns/1ps
interface hex_entry_ctrl_if #(
  parameter int DIGITS = 2
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [3:0]    din;
  logic          din_vld;
  logic          din_rdy;
  logic          enter;
  logic          abort;
  logic          tick;
  logic          co_in;
  logic          ld;
  logic          ce;
  logic [W-1:0]  d_out;
  logic          cnt_clr;
  logic          busy;
  logic          done;
  logic [CW-1:0] dig_cnt;

  modport master (
    output din, din_vld, enter, abort, tick, co_in,
    input  din_rdy, ld, ce, d_out, cnt_clr, busy, done, dig_cnt
  );

  modport slave (
    input  din, din_vld, enter, abort, tick, co_in,
    output din_rdy, ld, ce, d_out, cnt_clr, busy, done, dig_cnt
  );
endinterface

// File: rtl/hex_entry_ctrl.sv
// Assembles hex digits MSD-first, loads them into a cascade of 4-bit counters,
// then gates TICK into the chain until the top stage carries out.
`timescale 1ns/1ps
module hex_entry_ctrl #(
  parameter int DIGITS = 2,
  parameter bit RELOAD = 1'b0
) (
  input logic             clk,
  input logic             clr_n,
  hex_entry_ctrl_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] dig_cnt_q, dig_cnt_d;
  logic          ld_q, ld_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          done_q, done_d;

  logic          din_rdy;
  logic          accept;
  logic          ce;

  assign din_rdy = ((state_q == IDLE) || (state_q == ENTRY)) && (dig_cnt_q < DIG_MAX);
  assign accept  = bus.din_vld & din_rdy;
  assign ce      = (state_q == RUN) & bus.tick & ~bus.abort;

  // ABORT overrides everything; otherwise a shifted-in digit lands before ENTER takes effect.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    dig_cnt_d = dig_cnt_q;
    cnt_clr_d = 1'b0;
    done_d    = 1'b0;
    if (bus.abort) begin
      state_d   = IDLE;
      dig_cnt_d = '0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            buf_d     = W'(bus.din);
            dig_cnt_d = CW'(1);
            state_d   = ENTRY;
          end
        end
        ENTRY: begin
          if (accept) begin
            buf_d     = (buf_q << 4) | W'(bus.din);
            dig_cnt_d = dig_cnt_q + CW'(1);
          end
          if (bus.enter) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          state_d = RUN;
        end
        RUN: begin
          if (ce && bus.co_in) begin
            done_d = 1'b1;
            if (RELOAD) begin
              state_d = LOAD;
            end else begin
              state_d   = IDLE;
              dig_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    ld_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      dig_cnt_q <= '0;
      ld_q      <= 1'b0;
      cnt_clr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      dig_cnt_q <= dig_cnt_d;
      ld_q      <= ld_d;
      cnt_clr_q <= cnt_clr_d;
      done_q    <= done_d;
    end
  end

  assign bus.din_rdy = din_rdy;
  assign bus.ce      = ce;
  assign bus.ld      = ld_q;
  assign bus.d_out   = buf_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.done    = done_q;
  assign bus.dig_cnt = dig_cnt_q;
  assign bus.busy    = (state_q == LOAD) || (state_q == RUN);

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Randomized bench for hex_entry_ctrl: models the counter cascade and predicts
// entry values and tick-to-DONE distances from plain arithmetic.
`timescale 1ns/1ps
module tb_hex_entry_ctrl;

  localparam int DIGITS = 2;
  localparam int MOD    = 16 ** DIGITS;

  logic clk;
  logic clr_n;

  hex_entry_ctrl_if #(.DIGITS(DIGITS)) ifa ();
  hex_entry_ctrl_if #(.DIGITS(DIGITS)) ifb ();

  hex_entry_ctrl #(.DIGITS(DIGITS), .RELOAD(1'b0)) dut_a (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifa.slave)
  );

  hex_entry_ctrl #(.DIGITS(DIGITS), .RELOAD(1'b1)) dut_b (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifb.slave)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   chain_a     = 0;
  int   chain_b     = 0;
  logic force_co_a  = 1'b0;
  int   exp_value   = 0;
  int   exp_cnt     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural counter cascade: one wide modulo-16^DIGITS counter per controller.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)            chain_a <= 0;
    else if (ifa.ld)       chain_a <= int'(ifa.d_out);
    else if (ifa.cnt_clr)  chain_a <= 0;
    else if (ifa.ce)       chain_a <= (chain_a + 1) % MOD;
  end

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)            chain_b <= 0;
    else if (ifb.ld)       chain_b <= int'(ifb.d_out);
    else if (ifb.cnt_clr)  chain_b <= 0;
    else if (ifb.ce)       chain_b <= (chain_b + 1) % MOD;
  end

  assign ifa.co_in = force_co_a | (ifa.ce && (chain_a == MOD - 1));
  assign ifb.co_in = ifb.ce && (chain_b == MOD - 1);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] din, input logic vld, input logic enter,
                               input logic abort, input logic tick);
    ifa.din     = din;
    ifa.din_vld = vld;
    ifa.enter   = enter;
    ifa.abort   = abort;
    ifa.tick    = tick;
    #1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Offers each digit once; a fresh entry starts from zero, extra digits beyond DIGITS are refused.
  task automatic enter_digits(input logic [3:0] digs[$], input bit enter_with_last, input bit do_enter);
    bit loaded;
    bit en;
    bit acc;
    loaded = 1'b0;
    foreach (digs[i]) begin
      en  = enter_with_last && (i == digs.size() - 1);
      acc = (exp_cnt < DIGITS);
      applyStimulus(digs[i], 1'b1, en, 1'b0, 1'b0);
      checkOutput("din_rdy", 32'(ifa.din_rdy), 32'(acc));
      loaded = en && (exp_cnt > 0);
      if (acc) begin
        exp_value = (exp_cnt == 0) ? int'(digs[i]) : (exp_value * 16 + int'(digs[i])) % MOD;
        exp_cnt++;
      end
      next_edge();
      checkOutput("dig_cnt", 32'(ifa.dig_cnt), 32'(exp_cnt));
      checkOutput("d_out_entry", 32'(ifa.d_out), 32'(exp_value));
    end
    if (!loaded && do_enter) begin
      applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      loaded = 1'b1;
      next_edge();
    end
    if (loaded) begin
      checkOutput("ld_pulse", 32'(ifa.ld), 32'd1);
      checkOutput("busy_load", 32'(ifa.busy), 32'd1);
      checkOutput("load_value", 32'(ifa.d_out), 32'(exp_value));
    end
  endtask

  // Starts in LOAD; expects DONE after exactly 16^DIGITS - value granted ticks unless aborted first.
  task automatic run_count(input int abort_after, input bit dense);
    int   target;
    int   ticks;
    logic t;
    target = MOD - exp_value;
    ticks  = 0;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ce_in_load", 32'(ifa.ce), 32'd0);
    next_edge();
    checkOutput("ld_single", 32'(ifa.ld), 32'd0);
    for (int c = 0; c < 4 * MOD; c++) begin
      if (c == abort_after) begin
        force_co_a = 1'b1;
        applyStimulus(4'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1);
        checkOutput("ce_abort", 32'(ifa.ce), 32'd0);
        next_edge();
        force_co_a = 1'b0;
        exp_cnt = 0;
        checkOutput("done_abort", 32'(ifa.done), 32'd0);
        checkOutput("cnt_clr_abort", 32'(ifa.cnt_clr), 32'd1);
        checkOutput("busy_abort", 32'(ifa.busy), 32'd0);
        checkOutput("dig_cnt_abort", 32'(ifa.dig_cnt), 32'd0);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_edge();
        checkOutput("cnt_clr_pulse", 32'(ifa.cnt_clr), 32'd0);
        return;
      end
      t = dense ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(4'($urandom), 1'($urandom), 1'($urandom), 1'b0, t);
      checkOutput("ce_run", 32'(ifa.ce), 32'(t));
      checkOutput("din_rdy_run", 32'(ifa.din_rdy), 32'd0);
      next_edge();
      if (t) ticks++;
      if (ticks == target) begin
        exp_cnt = 0;
        checkOutput("done", 32'(ifa.done), 32'd1);
        checkOutput("busy_done", 32'(ifa.busy), 32'd0);
        checkOutput("dig_cnt_done", 32'(ifa.dig_cnt), 32'd0);
        checkOutput("d_out_kept", 32'(ifa.d_out), 32'(exp_value));
        checkOutput("chain_wrap", 32'(chain_a), 32'd0);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_edge();
        checkOutput("done_pulse", 32'(ifa.done), 32'd0);
        return;
      end
      checkOutput("done_early", 32'(ifa.done), 32'd0);
    end
    checkOutput("run_timeout", 32'(ticks), 32'(target));
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    next_edge();
    exp_cnt = 0;
  endtask

  initial begin
    logic [3:0] digs[$];
    int         n;

    clr_n       = 1'b0;
    ifb.din     = 4'h0;
    ifb.din_vld = 1'b0;
    ifb.enter   = 1'b0;
    ifb.abort   = 1'b0;
    ifb.tick    = 1'b0;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_ld", 32'(ifa.ld), 32'd0);
    checkOutput("rst_ce", 32'(ifa.ce), 32'd0);
    checkOutput("rst_din_rdy", 32'(ifa.din_rdy), 32'd1);
    checkOutput("rst_busy", 32'(ifa.busy), 32'd0);
    checkOutput("rst_d_out", 32'(ifa.d_out), 32'd0);
    repeat (2) @(posedge clk);
    #2 clr_n = 1'b1;

    // ENTER from IDLE has nothing to commit.
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_edge();
    checkOutput("idle_enter_busy", 32'(ifa.busy), 32'd0);
    checkOutput("idle_enter_ld", 32'(ifa.ld), 32'd0);

    digs = '{4'hF, 4'hD};
    enter_digits(digs, 1'b0, 1'b1);
    run_count(-1, 1'b1);

    digs = '{4'h0, 4'h7};
    enter_digits(digs, 1'b1, 1'b1);
    run_count(-1, 1'b0);

    digs = '{4'h1, 4'h2, 4'h3};
    enter_digits(digs, 1'b0, 1'b0);
    applyStimulus(4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
    next_edge();
    exp_cnt = 0;
    checkOutput("entry_abort_cnt", 32'(ifa.dig_cnt), 32'd0);
    checkOutput("entry_abort_clr", 32'(ifa.cnt_clr), 32'd1);
    checkOutput("entry_abort_rdy", 32'(ifa.din_rdy), 32'd1);

    digs = '{4'h3, 4'h4};
    enter_digits(digs, 1'b0, 1'b1);
    run_count(5, 1'b1);

    // Asynchronous reset in the middle of a count.
    digs = '{4'hA, 4'hB};
    enter_digits(digs, 1'b0, 1'b1);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      next_edge();
      checkOutput("pre_rst_done", 32'(ifa.done), 32'd0);
    end
    clr_n = 1'b0;
    #1;
    exp_cnt   = 0;
    exp_value = 0;
    checkOutput("midrun_ld", 32'(ifa.ld), 32'd0);
    checkOutput("midrun_ce", 32'(ifa.ce), 32'd0);
    checkOutput("midrun_done", 32'(ifa.done), 32'd0);
    checkOutput("midrun_cnt_clr", 32'(ifa.cnt_clr), 32'd0);
    checkOutput("midrun_din_rdy", 32'(ifa.din_rdy), 32'd1);
    checkOutput("midrun_d_out", 32'(ifa.d_out), 32'd0);
    checkOutput("midrun_busy", 32'(ifa.busy), 32'd0);
    next_edge();
    clr_n = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int iter = 0; iter < 10; iter++) begin
      n = $urandom_range(1, 3);
      digs = {};
      for (int k = 0; k < n; k++) digs.push_back(4'($urandom));
      enter_digits(digs, 1'($urandom), 1'b1);
      run_count(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, 1'($urandom));
    end

    // Auto-reload instance: FF reloads after every single tick.
    ifb.din     = 4'hF;
    ifb.din_vld = 1'b1;
    repeat (2) next_edge();
    ifb.din_vld = 1'b0;
    ifb.enter   = 1'b1;
    next_edge();
    ifb.enter   = 1'b0;
    checkOutput("b_ld", 32'(ifb.ld), 32'd1);
    checkOutput("b_d_out", 32'(ifb.d_out), 32'hFF);
    ifb.tick = 1'b1;
    next_edge();
    for (int r = 0; r < 4; r++) begin
      checkOutput("b_run_ld", 32'(ifb.ld), 32'd0);
      checkOutput("b_run_done", 32'(ifb.done), 32'd0);
      next_edge();
      checkOutput("b_done", 32'(ifb.done), 32'd1);
      checkOutput("b_reload_ld", 32'(ifb.ld), 32'd1);
      checkOutput("b_reload_val", 32'(ifb.d_out), 32'hFF);
      next_edge();
    end
    ifb.tick  = 1'b0;
    ifb.abort = 1'b1;
    next_edge();
    ifb.abort = 1'b0;
    checkOutput("b_abort_busy", 32'(ifb.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
